// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// compact CSR indices and mtvec mode encodings.
package csr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_W_MEPC   = 3'd1,
      ST_W_MCAUSE = 3'd2,
      ST_W_MTVAL  = 3'd3,
      ST_R_MTVEC  = 3'd4,
      ST_R_MEPC   = 3'd5,
      ST_REDIR    = 3'd6
   } state_e;

   localparam int unsigned CSR_IDX_MSTATUS  = 0;
   localparam int unsigned CSR_IDX_MTVEC    = 5;
   localparam int unsigned CSR_IDX_MSCRATCH = 64;
   localparam int unsigned CSR_IDX_MEPC     = 65;
   localparam int unsigned CSR_IDX_MCAUSE   = 66;
   localparam int unsigned CSR_IDX_MTVAL    = 67;

   localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_vec_calc.sv
// Combinational trap target: mtvec base, plus 4*cause for vectored interrupts.
// Bit XLEN-2 of the cause code falls out of 4*code modulo 2^XLEN, so it is not an input.
module trap_vec_calc #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-3:0] mtvec_base,
   input  logic            vec_mode,
   input  logic            irq,
   input  logic [XLEN-3:0] code_lo,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] base;
   logic [XLEN-1:0] offset;

   always_comb begin
      base   = {mtvec_base, 2'b00};
      offset = {code_lo, 2'b00};
      target = base;
      if (vec_mode && irq) begin
         target = base + offset;
      end
   end

endmodule

// File: rtl/csr_trap_seq.sv
// Trap/mret sequencer and arbiter for the single-port machine CSR file.
// Define CSR_MTVAL_EN to add the W_MTVAL state (mtval written after mcause).
module csr_trap_seq
   import csr_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned CSR_AW     = 12,
   parameter int unsigned IDX_MTVEC  = CSR_IDX_MTVEC,
   parameter int unsigned IDX_MEPC   = CSR_IDX_MEPC,
   parameter int unsigned IDX_MCAUSE = CSR_IDX_MCAUSE,
   parameter int unsigned IDX_MTVAL  = CSR_IDX_MTVAL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trap_req,
   input  logic [XLEN-1:0]   trap_cause,
   input  logic [XLEN-1:0]   trap_pc,
   input  logic [XLEN-1:0]   trap_val,
   input  logic              mret_req,
   input  logic              core_csr_w,
   input  logic [CSR_AW-1:0] core_csr,
   input  logic [XLEN-1:0]   core_wd,
   output logic [XLEN-1:0]   core_rd,
   output logic              csr_w,
   output logic [CSR_AW-1:0] csr,
   output logic [XLEN-1:0]   wd,
   input  logic [XLEN-1:0]   rd,
   output logic              stall,
   output logic              pc_redirect,
   output logic [XLEN-1:0]   redirect_pc
);

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   target_q, target_d;
   logic [XLEN-1:0]   vec_target;
`ifdef CSR_MTVAL_EN
   logic [XLEN-1:0]   val_q, val_d;
`endif

   // NOTE: sequential blocks use non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: the data latches are reset as well, so an aborted sequence never
   // leaves a stale target visible on redirect_pc.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= '0;
         cause_q  <= '0;
         target_q <= '0;
`ifdef CSR_MTVAL_EN
         val_q    <= '0;
`endif
      end else begin
         pc_q     <= pc_d;
         cause_q  <= cause_d;
         target_q <= target_d;
`ifdef CSR_MTVAL_EN
         val_q    <= val_d;
`endif
      end
   end

   // NOTE: every combinational output gets a default before the case, so no
   // path can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trap_req) begin
               state_d = ST_W_MEPC;
            end else if (mret_req) begin
               state_d = ST_R_MEPC;
            end
         end
         ST_W_MEPC:   state_d = ST_W_MCAUSE;
`ifdef CSR_MTVAL_EN
         ST_W_MCAUSE: state_d = ST_W_MTVAL;
`else
         ST_W_MCAUSE: state_d = ST_R_MTVEC;
`endif
         ST_W_MTVAL:  state_d = ST_R_MTVEC;
         ST_R_MTVEC:  state_d = ST_REDIR;
         ST_R_MEPC:   state_d = ST_REDIR;
         ST_REDIR:    state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_d     = pc_q;
      cause_d  = cause_q;
      target_d = target_q;
`ifdef CSR_MTVAL_EN
      val_d    = val_q;
`endif
      if (state_q == ST_IDLE && trap_req) begin
         pc_d    = trap_pc;
         cause_d = trap_cause;
`ifdef CSR_MTVAL_EN
         val_d   = trap_val;
`endif
      end
      if (state_q == ST_R_MTVEC) begin
         target_d = vec_target;
      end
      if (state_q == ST_R_MEPC) begin
         target_d = {rd[XLEN-1:1], 1'b0};
      end
   end

   // The core only owns the CSR port in a quiet IDLE cycle; an accepted
   // request suppresses any core write in that same cycle.
   always_comb begin
      csr   = core_csr;
      wd    = core_wd;
      csr_w = 1'b0;
      case (state_q)
         ST_IDLE: csr_w = core_csr_w & ~trap_req & ~mret_req;
         ST_W_MEPC: begin
            csr   = CSR_AW'(IDX_MEPC);
            wd    = pc_q;
            csr_w = 1'b1;
         end
         ST_W_MCAUSE: begin
            csr   = CSR_AW'(IDX_MCAUSE);
            wd    = cause_q;
            csr_w = 1'b1;
         end
`ifdef CSR_MTVAL_EN
         ST_W_MTVAL: begin
            csr   = CSR_AW'(IDX_MTVAL);
            wd    = val_q;
            csr_w = 1'b1;
         end
`endif
         ST_R_MTVEC: csr = CSR_AW'(IDX_MTVEC);
         ST_R_MEPC:  csr = CSR_AW'(IDX_MEPC);
         default: ;
      endcase
      if (rst) begin
         csr_w = 1'b0;
      end
   end

   assign stall       = (state_q != ST_IDLE) | trap_req | mret_req;
   assign pc_redirect = (state_q == ST_REDIR);
   assign redirect_pc = target_q;
   assign core_rd     = rd;

   trap_vec_calc #(
      .XLEN (XLEN)
   ) u_trap_vec_calc (
      .mtvec_base (rd[XLEN-1:2]),
      .vec_mode   (rd[0] == MTVEC_MODE_VECTORED[0]),
      .irq        (cause_q[XLEN-1]),
      .code_lo    (cause_q[XLEN-3:0]),
      .target     (vec_target)
   );

endmodule

// File: tb/tb_csr_trap_seq.sv
// Randomized bench for csr_trap_seq with a CSR-file model and a reference of
// architectural trap/mret effects. Honours CSR_MTVAL_EN.
module tb_csr_trap_seq;

   localparam int XLEN = 32;
   localparam int CSR_AW = 12;
`ifdef CSR_MTVAL_EN
   localparam int TRAP_LAT = 5;
   localparam bit MTVAL_EN = 1'b1;
`else
   localparam int TRAP_LAT = 4;
   localparam bit MTVAL_EN = 1'b0;
`endif
   localparam int MRET_LAT = 2;

   logic              clk;
   logic              rst;
   logic              trap_req;
   logic [XLEN-1:0]   trap_cause;
   logic [XLEN-1:0]   trap_pc;
   logic [XLEN-1:0]   trap_val;
   logic              mret_req;
   logic              core_csr_w;
   logic [CSR_AW-1:0] core_csr;
   logic [XLEN-1:0]   core_wd;
   logic [XLEN-1:0]   core_rd;
   logic              csr_w;
   logic [CSR_AW-1:0] csr;
   logic [XLEN-1:0]   wd;
   logic [XLEN-1:0]   rd;
   logic              stall;
   logic              pc_redirect;
   logic [XLEN-1:0]   redirect_pc;

   csr_trap_seq dut (
      .clk         (clk),
      .rst         (rst),
      .trap_req    (trap_req),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .trap_val    (trap_val),
      .mret_req    (mret_req),
      .core_csr_w  (core_csr_w),
      .core_csr    (core_csr),
      .core_wd     (core_wd),
      .core_rd     (core_rd),
      .csr_w       (csr_w),
      .csr         (csr),
      .wd          (wd),
      .rd          (rd),
      .stall       (stall),
      .pc_redirect (pc_redirect),
      .redirect_pc (redirect_pc)
   );

   // CSR file the DUT talks to: combinational read, write on the clock edge.
   logic [XLEN-1:0] csr_mem [0:4095];
   assign rd = csr_mem[csr];
   always @(posedge clk) begin
      if (csr_w) csr_mem[csr] <= wd;
   end

   // Reference: architectural CSR contents as the specification says they should be.
   logic [XLEN-1:0] ref_csr [0:4095];

   int errors = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_trap_target(input logic [31:0] mtvec, input logic [31:0] cause);
      logic [31:0] base;
      base = mtvec & 32'hFFFF_FFFC;
      if (mtvec[0] && cause[31]) return base + 32'd4 * (cause & 32'h7FFF_FFFF);
      return base;
   endfunction

   function automatic logic [11:0] pick_idx();
      case ($urandom_range(0, 5))
         0: return 12'd0;
         1: return 12'd5;
         2: return 12'd64;
         3: return 12'd65;
         4: return 12'd66;
         default: return 12'd67;
      endcase
   endfunction

   task automatic core_write(input logic [11:0] idx, input logic [31:0] data);
      core_csr   = idx;
      core_wd    = data;
      core_csr_w = 1'b1;
      #1;
      check("pt_csr_w", {31'b0, csr_w}, 32'd1);
      check("pt_csr", {20'b0, csr}, {20'b0, idx});
      check("pt_wd", wd, data);
      check("pt_stall", {31'b0, stall}, 32'd0);
      tick();
      core_csr_w = 1'b0;
      ref_csr[idx] = data;
   endtask

   task automatic core_read(input logic [11:0] idx);
      core_csr   = idx;
      core_csr_w = 1'b0;
      #1;
      check("pt_read", core_rd, ref_csr[idx]);
      tick();
   endtask

   task automatic check_arch_state(input string tag);
      check({tag, "_mepc"}, csr_mem[65], ref_csr[65]);
      check({tag, "_mcause"}, csr_mem[66], ref_csr[66]);
      check({tag, "_mtval"}, csr_mem[67], ref_csr[67]);
      check({tag, "_mscratch"}, csr_mem[64], ref_csr[64]);
   endtask

   // Trap with optional same-cycle mret, core write to 64 held during the
   // whole sequence, and an mret pulse while mcause is being written.
   task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] val,
                          input bit with_mret, input bit with_core_w, input bit late_mret);
      logic [31:0] exp_tgt;
      bit seen;
      exp_tgt    = exp_trap_target(ref_csr[5], cause);
      seen       = 1'b0;
      trap_req   = 1'b1;
      trap_pc    = pc;
      trap_cause = cause;
      trap_val   = val;
      mret_req   = with_mret;
      core_csr   = 12'd64;
      core_wd    = $urandom;
      core_csr_w = with_core_w;
      #1;
      check("trap_stall_req", {31'b0, stall}, 32'd1);
      check("trap_accept_csr_w", {31'b0, csr_w}, 32'd0);
      tick();
      trap_req = 1'b0;
      mret_req = 1'b0;
      trap_pc  = $urandom;
      for (int cyc = 1; cyc <= TRAP_LAT + 2; cyc++) begin
         if (late_mret && cyc == 2) mret_req = 1'b1;
         #1;
         check("trap_stall", {31'b0, stall}, 32'd1);
         if (pc_redirect) begin
            seen = 1'b1;
            check("trap_latency", 32'(cyc), 32'(TRAP_LAT));
            check("trap_target", redirect_pc, exp_tgt);
         end
         tick();
         mret_req = 1'b0;
         if (seen) break;
      end
      check("trap_redirect_seen", {31'b0, seen}, 32'd1);
      core_csr_w = 1'b0;
      ref_csr[65] = pc;
      ref_csr[66] = cause;
      if (MTVAL_EN) ref_csr[67] = val;
      #1;
      check("trap_idle_stall", {31'b0, stall}, 32'd0);
      check("trap_idle_redirect", {31'b0, pc_redirect}, 32'd0);
      check_arch_state("trap");
      tick();
   endtask

   task automatic do_mret(input bit with_core_w);
      logic [31:0] exp_tgt;
      bit seen;
      exp_tgt    = ref_csr[65] & 32'hFFFF_FFFE;
      seen       = 1'b0;
      mret_req   = 1'b1;
      core_csr   = 12'd64;
      core_wd    = $urandom;
      core_csr_w = with_core_w;
      #1;
      check("mret_stall_req", {31'b0, stall}, 32'd1);
      check("mret_accept_csr_w", {31'b0, csr_w}, 32'd0);
      tick();
      mret_req = 1'b0;
      for (int cyc = 1; cyc <= MRET_LAT + 2; cyc++) begin
         #1;
         check("mret_stall", {31'b0, stall}, 32'd1);
         if (pc_redirect) begin
            seen = 1'b1;
            check("mret_latency", 32'(cyc), 32'(MRET_LAT));
            check("mret_target", redirect_pc, exp_tgt);
         end
         tick();
         if (seen) break;
      end
      check("mret_redirect_seen", {31'b0, seen}, 32'd1);
      core_csr_w = 1'b0;
      #1;
      check("mret_idle_stall", {31'b0, stall}, 32'd0);
      check_arch_state("mret");
      tick();
   endtask

   // Reset while mcause is being written: mepc sticks, mcause must not change.
   task automatic do_reset_mid(input logic [31:0] pc, input logic [31:0] cause);
      trap_req   = 1'b1;
      trap_pc    = pc;
      trap_cause = cause;
      trap_val   = $urandom;
      tick();
      trap_req = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("rstmid_csr_w", {31'b0, csr_w}, 32'd0);
      tick();
      rst = 1'b0;
      ref_csr[65] = pc;
      #1;
      check("rstmid_redirect", {31'b0, pc_redirect}, 32'd0);
      check("rstmid_redirect_pc", redirect_pc, 32'd0);
      check("rstmid_stall", {31'b0, stall}, 32'd0);
      check_arch_state("rstmid");
      tick();
   endtask

   initial begin
      trap_req   = 1'b0;
      trap_cause = '0;
      trap_pc    = '0;
      trap_val   = '0;
      mret_req   = 1'b0;
      core_csr_w = 1'b1;
      core_csr   = 12'd64;
      core_wd    = 32'hFFFF_FFFF;
      rst        = 1'b1;
      repeat (2) tick();
      check("rst_csr_w_forced", {31'b0, csr_w}, 32'd0);
      check("rst_redirect", {31'b0, pc_redirect}, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      rst        = 1'b0;
      core_csr_w = 1'b0;
      #1;
      check("rst_idle_stall", {31'b0, stall}, 32'd0);
      tick();

      core_write(12'd0, 32'd0);
      core_write(12'd5, 32'd0);
      core_write(12'd64, 32'd0);
      core_write(12'd65, 32'd0);
      core_write(12'd66, 32'd0);
      core_write(12'd67, 32'd0);

      core_write(12'd64, 32'hDEAD_BEEF);
      core_read(12'd64);

      core_write(12'd5, 32'h0000_0100);
      do_trap(32'h0000_0040, 32'd2, 32'h0000_1234, 1'b0, 1'b0, 1'b0);

      core_write(12'd5, 32'h0000_0201);
      do_trap(32'h0000_0080, 32'h8000_0007, 32'h0000_1234, 1'b0, 1'b0, 1'b0);

      core_write(12'd65, 32'h0000_0044);
      do_mret(1'b0);

      do_trap(32'h0000_0100, 32'h0000_000B, 32'h0000_5678, 1'b1, 1'b1, 1'b1);

      do_reset_mid(32'h0000_0088, 32'h0000_0005);

      for (int n = 0; n < 60; n++) begin
         logic [31:0] c;
         case ($urandom_range(0, 5))
            0: core_write(pick_idx(), $urandom);
            1: core_read(pick_idx());
            2, 3: begin
               c = $urandom;
               if ($urandom_range(0, 1) == 1) c = {c[31], 26'b0, c[4:0]};
               do_trap($urandom, c, $urandom, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            4: do_mret(1'($urandom_range(0, 1)));
            default: do_reset_mid($urandom, $urandom);
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
